// File: rtl/rx_frame_controller.sv
// Receive-side frame controller: sequences data/parity/stop phases from the UART
// deserializer, checks each frame, and buffers good bytes in a small FIFO.
module rx_frame_controller #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int PARITY_ODD       = 0,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_enable_req,
  input  logic                        byte_done,
  input  logic [INPUT_DATA_WIDTH-1:0] received_data,
  input  logic                        parity_done,
  input  logic                        parity_bit,
  input  logic                        stop_done,
  input  logic                        stop_bit,
  output logic                        rx_enable,
  output logic [INPUT_DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        overrun,
  input  logic                        clear_errors,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    WAIT_PARITY,
    WAIT_STOP,
    COMMIT
  } state_t;

  state_t                      state_reg, state_next;
  logic [TMO_W-1:0]            tmo_reg, tmo_next;
  logic [INPUT_DATA_WIDTH-1:0] data_reg;
  logic                        parity_bad_reg;
  logic                        stop_ok_reg;
  logic                        timeout;

  logic [INPUT_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]            count_reg, count_next;
  logic [INPUT_DATA_WIDTH-1:0] out_data_reg, head_next;
  logic                        parity_error_reg, framing_error_reg, overrun_reg;

  logic commit, full, pop, push;
  logic set_framing, set_parity, set_overrun;

  // Phase sequencing; tmo_next defaults to zero so state entry and pulses restart it.
  always_comb begin
    state_next = state_reg;
    tmo_next   = '0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_enable_req) state_next = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (byte_done) state_next = WAIT_PARITY;
      end
      WAIT_PARITY: begin
        if (parity_done) begin
          state_next = WAIT_STOP;
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = WAIT_BYTE;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      WAIT_STOP: begin
        if (stop_done) begin
          state_next = COMMIT;
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = WAIT_BYTE;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      COMMIT: begin
        state_next = rx_enable_req ? WAIT_BYTE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      tmo_reg        <= '0;
      data_reg       <= '0;
      parity_bad_reg <= 1'b0;
      stop_ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      if (state_reg == WAIT_BYTE && byte_done)
        data_reg <= received_data;
      if (state_reg == WAIT_PARITY && parity_done)
        parity_bad_reg <= ((^data_reg) ^ 1'(PARITY_ODD)) != parity_bit;
      if (state_reg == WAIT_STOP && stop_done)
        stop_ok_reg <= stop_bit;
    end
  end

  // Commit decision: a pop in the same cycle frees a slot in a full FIFO.
  assign commit      = (state_reg == COMMIT);
  assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop         = out_valid && out_ready;
  assign set_framing = (commit && !stop_ok_reg) || timeout;
  assign set_parity  = commit && stop_ok_reg && parity_bad_reg;
  assign set_overrun = commit && stop_ok_reg && !parity_bad_reg && full && !pop;
  assign push        = commit && stop_ok_reg && !parity_bad_reg && (!full || pop);

  always_comb begin
    rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (pop && !push) count_next = count_reg - CNT_W'(1);
    // A byte written this cycle becomes the head only when the FIFO drains to it.
    head_next = (push && wr_ptr_reg == rd_ptr_next) ? data_reg : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= data_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      out_data_reg <= head_next;
    end
  end

  // Sticky flags: a new error in the same cycle as clear_errors wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_error_reg  <= 1'b0;
      framing_error_reg <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      parity_error_reg  <= set_parity  | (parity_error_reg  & ~clear_errors);
      framing_error_reg <= set_framing | (framing_error_reg & ~clear_errors);
      overrun_reg       <= set_overrun | (overrun_reg       & ~clear_errors);
    end
  end

  assign rx_enable     = (state_reg != IDLE);
  assign out_valid     = (count_reg != '0);
  assign out_data      = out_data_reg;
  assign fifo_count    = count_reg;
  assign parity_error  = parity_error_reg;
  assign framing_error = framing_error_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench for rx_frame_controller: frame checks, error flags, FIFO
// overrun/wrap, simultaneous push/pop when full, timeout and async reset.
module tb_rx_frame_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_enable_req, byte_done, parity_done, parity_bit, stop_done, stop_bit;
  logic [7:0] received_data;
  logic       rx_enable, out_valid, out_ready;
  logic [7:0] out_data;
  logic       parity_error, framing_error, overrun, clear_errors;
  logic [2:0] fifo_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rx_frame_controller #(
    .INPUT_DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_ODD(0), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .reset(reset), .rx_enable_req(rx_enable_req),
    .byte_done(byte_done), .received_data(received_data),
    .parity_done(parity_done), .parity_bit(parity_bit),
    .stop_done(stop_done), .stop_bit(stop_bit),
    .rx_enable(rx_enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .parity_error(parity_error),
    .framing_error(framing_error), .overrun(overrun),
    .clear_errors(clear_errors), .fifo_count(fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Every accepted byte is compared against the bench's own expected order.
  always begin
    @(negedge clk);
    #2;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", exp_q.size(), 1);
      else                   check("pop_data", out_data, exp_q.pop_front());
    end
  end

  // Starts at a negedge with the FSM in WAIT_BYTE; returns at the negedge two cycles after stop_done.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic rdy_commit, input logic clr_commit);
    byte_done = 1'b1; received_data = d;
    @(negedge clk); byte_done = 1'b0;
    parity_done = 1'b1; parity_bit = p;
    @(negedge clk); parity_done = 1'b0;
    stop_done = 1'b1; stop_bit = s;
    @(negedge clk); stop_done = 1'b0;
    if (rdy_commit) out_ready = 1'b1;
    if (clr_commit) clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    if (rdy_commit) out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    int n;
    reset = 1'b0; rx_enable_req = 1'b0; byte_done = 1'b0; parity_done = 1'b0;
    stop_done = 1'b0; parity_bit = 1'b0; stop_bit = 1'b0; received_data = 8'h00;
    out_ready = 1'b0; clear_errors = 1'b0;
    #2;
    check("rst_rx_enable", rx_enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_flags", {parity_error, framing_error, overrun}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("idle_rx_enable", rx_enable, 0);
    rx_enable_req = 1'b1;
    @(negedge clk);
    check("enable_rise", rx_enable, 1);

    // Good frame 0xA5, even parity 0
    byte_done = 1'b1; received_data = 8'hA5;
    @(negedge clk); byte_done = 1'b0; parity_done = 1'b1; parity_bit = 1'b0;
    @(negedge clk); parity_done = 1'b0; stop_done = 1'b1; stop_bit = 1'b1;
    @(negedge clk); stop_done = 1'b0;
    check("good_commit_valid", out_valid, 0);
    @(negedge clk);
    check("good_valid", out_valid, 1);
    check("good_data", out_data, 8'hA5);
    check("good_flags", {parity_error, framing_error, overrun}, 0);
    exp_q.push_back(8'hA5);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("good_drained", out_valid, 0);

    // Parity error then clear
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    check("par_err", parity_error, 1);
    check("par_fifo", fifo_count, 0);
    pulse_clear();
    check("par_cleared", parity_error, 0);

    // Framing error, with clear_errors in the same cycle: set wins
    send_frame(8'h42, even_par(8'h42), 1'b0, 1'b0, 1'b1);
    check("frm_err", framing_error, 1);
    check("frm_fifo", fifo_count, 0);
    pulse_clear();
    check("frm_cleared", framing_error, 0);

    // Overrun and wrap
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), even_par(8'h10 + 8'(i)), 1'b1, 1'b0, 1'b0);
      if (i < 4) exp_q.push_back(8'h10 + 8'(i));
    end
    check("ovr_count", fifo_count, 4);
    check("ovr_flag", overrun, 1);
    check("ovr_head", out_data, 8'h10);
    out_ready = 1'b1;
    wait_drained("ovr_drain");
    check("ovr_empty", fifo_count, 0);
    for (int i = 0; i < 6; i++) begin
      send_frame(8'h15 + 8'(i), even_par(8'h15 + 8'(i)), 1'b1, 1'b1, 1'b0);
      out_ready = 1'b1;
      exp_q.push_back(8'h15 + 8'(i));
    end
    wait_drained("wrap_drain");
    out_ready = 1'b0;
    pulse_clear();
    check("ovr_cleared", overrun, 0);

    // Full with simultaneous pop in the COMMIT cycle
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h20 + 8'(i), even_par(8'h20 + 8'(i)), 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h20 + 8'(i));
    end
    check("full_count", fifo_count, 4);
    send_frame(8'h24, even_par(8'h24), 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h24);
    check("fullpop_count", fifo_count, 4);
    check("fullpop_overrun", overrun, 0);
    check("fullpop_head", out_data, 8'h21);
    out_ready = 1'b1;
    wait_drained("fullpop_drain");
    out_ready = 1'b0;

    // Request dropped mid-frame: frame completes, then IDLE
    rx_enable_req = 1'b0;
    send_frame(8'h66, even_par(8'h66), 1'b1, 1'b0, 1'b0);
    check("req_drop_idle", rx_enable, 0);
    check("req_drop_count", fifo_count, 1);
    exp_q.push_back(8'h66);
    out_ready = 1'b1;
    wait_drained("req_drop_drain");
    out_ready = 1'b0;
    rx_enable_req = 1'b1;
    @(negedge clk);
    check("req_reenable", rx_enable, 1);

    // Timeout in WAIT_PARITY
    byte_done = 1'b1; received_data = 8'h77;
    @(negedge clk); byte_done = 1'b0;
    n = 1;
    while (!framing_error && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 4097);
    check("tmo_flag", framing_error, 1);
    check("tmo_rx_enable", rx_enable, 1);
    pulse_clear();
    parity_done = 1'b1; stop_done = 1'b1; stop_bit = 1'b1;
    @(negedge clk); parity_done = 1'b0; stop_done = 1'b0;
    @(negedge clk); @(negedge clk);
    check("stray_pulses", fifo_count, 0);
    send_frame(8'h5A, even_par(8'h5A), 1'b1, 1'b0, 1'b0);
    check("tmo_recover_data", out_data, 8'h5A);
    check("tmo_recover_flags", {parity_error, framing_error, overrun}, 0);
    exp_q.push_back(8'h5A);
    out_ready = 1'b1;
    wait_drained("tmo_drain");
    out_ready = 1'b0;

    // Async reset in WAIT_STOP with two bytes buffered and a sticky error
    send_frame(8'h30, even_par(8'h30), 1'b1, 1'b0, 1'b0);
    send_frame(8'h31, even_par(8'h31), 1'b1, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", fifo_count, 2);
    check("pre_rst_par", parity_error, 1);
    byte_done = 1'b1; received_data = 8'h55;
    @(negedge clk); byte_done = 1'b0; parity_done = 1'b1; parity_bit = 1'b0;
    @(negedge clk); parity_done = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("arst_rx_enable", rx_enable, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_fifo_count", fifo_count, 0);
    check("arst_flags", {parity_error, framing_error, overrun}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_enable", rx_enable, 1);
    send_frame(8'h3C, even_par(8'h3C), 1'b1, 1'b0, 1'b0);
    check("post_rst_count", fifo_count, 1);
    check("post_rst_data", out_data, 8'h3C);
    exp_q.push_back(8'h3C);
    out_ready = 1'b1;
    wait_drained("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
